// File: rtl/detectfaces_mul_pkg.sv
// Shared constants and constant functions for the pipelined multiplier.
package detectfaces_mul_pkg;

  // Working width for saturation limits and range comparisons.
  localparam int MAXW = 128;

  // Width of the exact signed product of two extended operands.
  function automatic int calc_pw(input int a_width, input int b_width);
    return a_width + b_width + 2;
  endfunction

  // Largest two's-complement value representable in w bits.
  function automatic logic signed [MAXW-1:0] sat_max(input int w);
    logic signed [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest two's-complement value representable in w bits.
  function automatic logic signed [MAXW-1:0] sat_min(input int w);
    logic signed [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return -(one <<< (w - 1));
  endfunction

  // Legal pipeline depth.
  function automatic bit stage_ok(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  // Legal right-shift amount for the given operand widths.
  function automatic bit shift_ok(input int s, input int a_width, input int b_width);
    return (s >= 0) && (s <= a_width + b_width - 1);
  endfunction

endpackage

// File: rtl/detectfaces_mul_sat.sv
// Combinational arithmetic right shift (floor) followed by clipping to dout_WIDTH.
module detectfaces_mul_sat
  import detectfaces_mul_pkg::*;
#(
  parameter int PW         = 27,
  parameter int SHIFT      = 0,
  parameter int dout_WIDTH = 24
)(
  input  logic signed [PW-1:0]   p,
  output logic [dout_WIDTH-1:0]  dout,
  output logic                   sat
);

  logic signed [PW-1:0]   s;
  logic signed [MAXW-1:0] s_wide;

  // Arithmetic shift keeps the sign, so rounding is toward minus infinity.
  assign s      = p >>> SHIFT;
  assign s_wide = {{(MAXW-PW){s[PW-1]}}, s};

  generate
    if (PW - SHIFT <= dout_WIDTH) begin : g_fit
      // The scaled value always fits, so no clipping logic is built.
      logic unused_hi;
      assign unused_hi = ^s_wide[MAXW-1:dout_WIDTH];
      assign dout      = s_wide[dout_WIDTH-1:0];
      assign sat       = 1'b0;
    end else begin : g_clip
      localparam logic signed [MAXW-1:0] MAX_V = sat_max(dout_WIDTH);
      localparam logic signed [MAXW-1:0] MIN_V = sat_min(dout_WIDTH);
      // Clip to the representable range and flag when clipping happened.
      always_comb begin
        dout = s_wide[dout_WIDTH-1:0];
        sat  = 1'b0;
        if (s_wide > MAX_V) begin
          dout = MAX_V[dout_WIDTH-1:0];
          sat  = 1'b1;
        end else if (s_wide < MIN_V) begin
          dout = MIN_V[dout_WIDTH-1:0];
          sat  = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/detectfaces_mul_pipe.sv
// Pipelined multiplier with valid/ready flow control, per-transaction signedness,
// fixed-point right shift and output saturation. One global enable stalls every stage.
module detectfaces_mul_pipe
  import detectfaces_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 24,
  parameter int SHIFT      = 0
)(
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [din0_WIDTH-1:0]  din0,
  input  logic [din1_WIDTH-1:0]  din1,
  input  logic                   din0_signed,
  input  logic                   din1_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [dout_WIDTH-1:0]  dout,
  output logic                   sat
);

  localparam int PW = calc_pw(din0_WIDTH, din1_WIDTH);
  localparam int AW = din0_WIDTH + 1;
  localparam int BW = din1_WIDTH + 1;
  localparam int unused_id = ID;

  generate
    if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
      $error("NUM_STAGE must be in 1..4");
    end
    if (!shift_ok(SHIFT, din0_WIDTH, din1_WIDTH)) begin : g_bad_shift
      $error("SHIFT must be in 0..din0_WIDTH+din1_WIDTH-1");
    end
    if (PW >= MAXW) begin : g_bad_width
      $error("operand widths too large for saturation arithmetic");
    end
  endgenerate

  logic                   adv;
  logic [NUM_STAGE:1]     vld;
  logic                   feed_valid;
  logic signed [AW-1:0]   a_in;
  logic signed [BW-1:0]   b_in;
  logic signed [AW-1:0]   mul_a;
  logic signed [BW-1:0]   mul_b;
  logic signed [PW-1:0]   mul_p;
  logic signed [PW-1:0]   p_last;
  logic [dout_WIDTH-1:0]  dout_comb;
  logic                   sat_comb;

  // Extend by one bit: sign bit copied only when the operand is flagged signed.
  assign a_in = {din0_signed & din0[din0_WIDTH-1], din0};
  assign b_in = {din1_signed & din1[din1_WIDTH-1], din1};

  // A stage may move only when the output slot is empty or being drained.
  assign out_valid = vld[NUM_STAGE];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = ap_rst_n && adv;

  // Low PW bits of the modular product are exact, since PW bits hold any product.
  assign mul_p = {{(PW-AW){mul_a[AW-1]}}, mul_a} * {{(PW-BW){mul_b[BW-1]}}, mul_b};

  // Valid chain: bubbles shift along like data, nothing is collapsed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[1] <= in_valid;
      for (int i = 2; i <= NUM_STAGE; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_one
      // Single stage: multiply, shift and clip all sit in front of the output flop.
      assign mul_a      = a_in;
      assign mul_b      = b_in;
      assign p_last     = mul_p;
      assign feed_valid = in_valid;
    end else begin : g_multi
      logic signed [AW-1:0] a_reg;
      logic signed [BW-1:0] b_reg;

      // Stage 1 captures operands already extended according to their flags.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_in;
          b_reg <= b_in;
        end
      end

      assign mul_a      = a_reg;
      assign mul_b      = b_reg;
      assign feed_valid = vld[NUM_STAGE-1];

      if (NUM_STAGE == 2) begin : g_direct
        assign p_last = mul_p;
      end else begin : g_prod
        logic signed [PW-1:0] prod_reg [2:NUM_STAGE-1];

        // Middle stages carry the full product toward the output stage.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int i = 2; i <= NUM_STAGE - 1; i++) begin
              prod_reg[i] <= '0;
            end
          end else if (adv) begin
            prod_reg[2] <= mul_p;
            for (int i = 3; i <= NUM_STAGE - 1; i++) begin
              prod_reg[i] <= prod_reg[i-1];
            end
          end
        end

        assign p_last = prod_reg[NUM_STAGE-1];
      end
    end
  endgenerate

  detectfaces_mul_sat #(
    .PW         (PW),
    .SHIFT      (SHIFT),
    .dout_WIDTH (dout_WIDTH)
  ) u_sat (
    .p    (p_last),
    .dout (dout_comb),
    .sat  (sat_comb)
  );

  // Output stage: only a valid incoming result overwrites dout and sat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (adv && feed_valid) begin
      dout <= dout_comb;
      sat  <= sat_comb;
    end
  end

endmodule
